if_id_buf: RTL and testbench

- Two-entry instruction buffer and pipeline latch between instruction fetch and decode.
- Accepts (instruction, PC+2) pairs from fetch with a valid/ready handshake and presents them registered to decode.
- Absorbs one cycle of decode back-pressure without losing a fetched word.
- Supports branch/jump flush and HALT capture, so fetch stalls cleanly once a HALT has been passed downstream.

---
 rtl/if_id_buf_pkg.sv | 17 +
 rtl/if_id_buf_if.sv | 25 ++
 rtl/if_id_buf_entry.sv | 27 ++
 rtl/if_id_buf.sv | 68 ++++++
 tb/tb_if_id_buf.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_buf_pkg.sv
// Shared widths, encodings and the pipe word carried from fetch to decode.
package if_id_buf_pkg;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] NOP_INSTR  = 16'h0800;
  localparam logic [DATA_W-1:0] HALT_INSTR = 16'h0000;
  localparam int OP_HI = 15;
  localparam int OP_LO = 11;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_inc;
  } pipe_word_t;

  function automatic logic is_halt(input logic [DATA_W-1:0] instr);
    return instr[OP_HI:OP_LO] == HALT_INSTR[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/if_id_buf_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
// A word moves on a rising edge exactly when valid and ready are both high;
// valid never depends on ready, and ready never depends on the same-cycle valid.
interface if_id_buf_if;
  import if_id_buf_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc_inc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc_inc;

  modport slave (
    input  in_valid, in_instr, in_pc_inc, out_ready,
    output in_ready, out_valid, out_instr, out_pc_inc
  );

  modport master (
    output in_valid, in_instr, in_pc_inc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc_inc
  );
endinterface

// File: rtl/if_id_buf_entry.sv
// One valid+word register; clear wins over load.
module if_id_entry
  import if_id_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  pipe_word_t d,
  output logic       valid,
  output pipe_word_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/if_id_buf.sv
// Two-entry IF/ID buffer: head register feeds decode, skid register absorbs
// one cycle of back-pressure; flush empties it, HALT blocks further input.
module if_id_buf
  import if_id_buf_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  if_id_buf_if.slave   bus,
  output logic         halt_seen,
  output logic [1:0]   occupancy
);

  pipe_word_t in_word, head_d, head_q, skid_q;
  logic head_valid, skid_valid;
  logic head_load, head_clr, skid_load, skid_clr;
  logic push, pop;

  // The skid entry is only ever valid behind a valid head, so the count is exact.
  assign occupancy    = {1'b0, head_valid} + {1'b0, skid_valid};
  assign bus.in_ready = ~skid_valid & ~halt_seen & ~flush;

  assign push    = bus.in_valid & bus.in_ready;
  assign pop     = head_valid & bus.out_ready;
  assign in_word = '{instr: bus.in_instr, pc_inc: bus.in_pc_inc};

  // Head takes the skid word when draining from full, otherwise the fetched word.
  assign head_d    = skid_valid ? skid_q : in_word;
  assign head_load = ~flush & ((push & (~head_valid | pop)) | (pop & skid_valid));
  assign head_clr  = flush | (pop & ~push & ~skid_valid);
  assign skid_load = ~flush & push & ~pop & head_valid;
  assign skid_clr  = flush | (pop & skid_valid);

  if_id_entry u_head (
    .clk   (clk),
    .rst   (rst),
    .clear (head_clr),
    .load  (head_load),
    .d     (head_d),
    .valid (head_valid),
    .q     (head_q)
  );

  if_id_entry u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (skid_clr),
    .load  (skid_load),
    .d     (in_word),
    .valid (skid_valid),
    .q     (skid_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_seen <= 1'b0;
    end else if (flush) begin
      halt_seen <= 1'b0;
    end else if (push && is_halt(bus.in_instr)) begin
      halt_seen <= 1'b1;
    end
  end

  assign bus.out_valid  = head_valid;
  assign bus.out_instr  = head_valid ? head_q.instr  : NOP_INSTR;
  assign bus.out_pc_inc = head_valid ? head_q.pc_inc : '0;

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf against a queue-based reference model.
module tb_if_id_buf;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       halt_seen;
  logic [1:0] occupancy;

  if_id_buf_if bus ();

  if_id_buf dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .halt_seen (halt_seen),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: held words as {instr, pc_inc}, oldest first
  logic [31:0] exp_q[$];
  logic        m_halt;
  logic [15:0] dut_deliv[$];
  int          n_checks;
  int          n_fail;

  function automatic logic [36:0] obs();
    return {bus.out_valid, bus.out_instr, bus.out_pc_inc, occupancy, halt_seen, bus.in_ready};
  endfunction

  function automatic logic [36:0] exp_obs();
    logic        v;
    logic [15:0] i;
    logic [15:0] p;
    logic        r;
    v = (exp_q.size() != 0);
    i = v ? exp_q[0][31:16] : 16'h0800;
    p = v ? exp_q[0][15:0]  : 16'h0000;
    r = (exp_q.size() < 2) && !m_halt && !flush;
    return {v, i, p, 2'(exp_q.size()), m_halt, r};
  endfunction

  // driver: set inputs just after the falling edge, settle 1 time unit
  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] p,
                       input logic f, input logic r);
    bus.in_valid  = v;
    bus.in_instr  = i;
    bus.in_pc_inc = p;
    flush         = f;
    bus.out_ready = r;
    #1;
  endtask

  // advance one rising edge, updating the model from the inputs being applied
  task automatic tick();
    logic m_push;
    logic m_pop;
    if (bus.out_valid && bus.out_ready) dut_deliv.push_back(bus.out_instr);
    if (!rst) begin
      exp_q.delete();
      m_halt = 1'b0;
    end else begin
      m_push = bus.in_valid && (exp_q.size() < 2) && !m_halt && !flush;
      m_pop  = (exp_q.size() > 0) && bus.out_ready;
      if (flush) begin
        exp_q.delete();
        m_halt = 1'b0;
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) begin
          exp_q.push_back({bus.in_instr, bus.in_pc_inc});
          if (bus.in_instr < 16'h0800) m_halt = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got=%h exp=%h", c, obs(), exp_obs());
      end
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    n_checks++;
    if (obs() !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", obs(), {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_streaming();
    logic [15:0] vi[3] = '{16'h4004, 16'h4105, 16'h0000};
    logic [15:0] vp[3] = '{16'h0002, 16'h0004, 16'h0000};
    dut_deliv.delete();
    for (int c = 0; c < 3; c++) begin
      drive(c < 2, vi[c], vp[c], 1'b0, 1'b1);
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL streaming c=%0d got=%h exp=%h", c, obs(), exp_obs());
      end
      tick();
    end
    n_checks++;
    if (dut_deliv.size() !== 2 || dut_deliv[0] !== 16'h4004 || dut_deliv[1] !== 16'h4105) begin
      n_fail++;
      $display("FAIL streaming_order got_count=%0d exp_count=2", dut_deliv.size());
    end
  endtask

  task automatic test_back_pressure();
    logic [15:0] vi[6] = '{16'h5A01, 16'h5B02, 16'h5C03, 16'h5C03, 16'h5C03, 16'h0000};
    logic        vv[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        vr[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    dut_deliv.delete();
    for (int c = 0; c < 6; c++) begin
      drive(vv[c], vi[c], 16'h0100 + 16'(c), 1'b0, vr[c]);
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL back_pressure c=%0d got=%h exp=%h", c, obs(), exp_obs());
      end
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (dut_deliv.size() !== 3 || dut_deliv[0] !== 16'h5A01 || dut_deliv[1] !== 16'h5B02 ||
        dut_deliv[2] !== 16'h5C03) begin
      n_fail++;
      $display("FAIL back_pressure_order got_count=%0d exp_count=3", dut_deliv.size());
    end
  endtask

  task automatic test_flush();
    logic found;
    dut_deliv.delete();
    drive(1'b1, 16'h7101, 16'h0020, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h7202, 16'h0022, 1'b0, 1'b0); tick();
    // single-cycle flush with a word offered, then a multi-cycle flush
    for (int c = 0; c < 6; c++) begin
      drive(c != 1 && c != 5, 16'h6000, 16'h0030, c == 0 || (c >= 2 && c <= 4), 1'b1);
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL flush c=%0d got=%h exp=%h", c, obs(), exp_obs());
      end
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_empty got=%h exp=%h", obs(), {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b0, 1'b1});
    end
    found = 1'b0;
    for (int k = 0; k < 2; k++) if (dut_deliv.size() > k && dut_deliv[k] == 16'h6000) found = 1'b1;
    n_checks++;
    if (found !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_dropped got=%b exp=0", found);
    end
  endtask

  task automatic test_halt_flush();
    logic found;
    dut_deliv.delete();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, (c == 0) ? 16'h0000 : 16'h4004, 16'h0040 + 16'(c), 1'b0, 1'b1);
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL halt c=%0d got=%h exp=%h", c, obs(), exp_obs());
      end
      tick();
    end
    n_checks++;
    if (halt_seen !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_block got=%b%b exp=10", halt_seen, bus.in_ready);
    end
    found = 1'b0;
    foreach (dut_deliv[k]) if (dut_deliv[k] == 16'h4004) found = 1'b1;
    n_checks++;
    if (dut_deliv.size() !== 1 || dut_deliv[0] !== 16'h0000 || found !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_deliver got_count=%0d exp_count=1 blocked_seen=%b", dut_deliv.size(), found);
    end
    drive(1'b1, 16'h4004, 16'h0050, 1'b1, 1'b1); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_checks++;
    if ({halt_seen, bus.in_ready} !== 2'b01 || obs() !== exp_obs()) begin
      n_fail++;
      $display("FAIL halt_flush got=%h exp=%h", obs(), exp_obs());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h3111, 16'h0060, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h3222, 16'h0062, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL async_setup got=%0d exp=2", occupancy);
    end
    #2 rst = 1'b0;
    exp_q.delete();
    m_halt = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || occupancy !== 2'd0 || obs() !== exp_obs()) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", obs(), exp_obs());
    end
    tick();
    rst = 1'b1;
    drive(1'b1, 16'h3333, 16'h0064, 1'b0, 1'b1);
    n_checks++;
    if (obs() !== exp_obs()) begin
      n_fail++;
      $display("FAIL async_release got=%h exp=%h", obs(), exp_obs());
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] ri;
    for (int c = 0; c < 400; c++) begin
      ri = ($urandom_range(0, 11) == 0) ? 16'($urandom_range(0, 16'h07ff)) : 16'($urandom);
      drive($urandom_range(0, 3) != 0, ri, 16'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0);
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_fail++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs(), exp_obs());
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_halt   = 1'b0;
    rst      = 1'b0;
    flush    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc_inc = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_halt_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
